// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back has fixed priority,
// LLU results queue in a small FIFO and drain on idle cycles or forced stalls.
module wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          pipe_wen_i,
   input  logic [4:0]                    pipe_rd_addr_i,
   input  logic [XLEN-1:0]               pipe_rd_data_i,
   input  logic                          pipe_instret_i,
   input  logic                          llu_valid_i,
   output logic                          llu_ready_o,
   input  logic [4:0]                    llu_rd_addr_i,
   input  logic [XLEN-1:0]               llu_rd_data_i,
   output logic                          stall_o,
   output logic                          regs_wen_o,
   output logic [4:0]                    rd_addr_o,
   output logic [XLEN-1:0]               rd_data_o,
   output logic [1:0]                    instret_cnt_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [XLEN-1:0] data_mem [FIFO_DEPTH];
   logic [4:0]      addr_mem [FIFO_DEPTH];
   logic [PW-1:0]   rptr;
   logic [PW-1:0]   wptr;
   logic [CW-1:0]   count;
   logic [SW-1:0]   starve;
   logic            stall_q;

   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            pipe_win;
   logic            starve_inc;
   logic            stall_d;
   logic [4:0]      head_addr;
   logic [XLEN-1:0] head_data;

   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign head_addr = addr_mem[rptr];
   assign head_data = data_mem[rptr];

   // Stalled cycles ignore the pipeline entirely; the FIFO head takes the port.
   always_comb begin
      llu_ready_o   = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      pipe_win      = 1'b0;
      starve_inc    = 1'b0;
      stall_d       = 1'b0;
      regs_wen_o    = 1'b0;
      rd_addr_o     = '0;
      rd_data_o     = '0;
      instret_cnt_o = '0;
      stall_o       = 1'b0;
      fifo_cnt_o    = '0;
      if (rstn) begin
         llu_ready_o = !full;
         push        = llu_valid_i && !full;
         pipe_win    = !stall_q && pipe_wen_i;
         pop         = !pipe_win && !empty;
         starve_inc  = pipe_win && !empty;
         stall_d     = starve_inc && (starve == SW'(STARVE_MAX - 1));
         stall_o     = stall_q;
         fifo_cnt_o  = count;
         if (pipe_win) begin
            regs_wen_o = (pipe_rd_addr_i != 5'd0);
            rd_addr_o  = pipe_rd_addr_i;
            rd_data_o  = pipe_rd_data_i;
         end else if (pop) begin
            regs_wen_o = (head_addr != 5'd0);
            rd_addr_o  = head_addr;
            rd_data_o  = head_data;
         end
         instret_cnt_o = {1'b0, pipe_instret_i && !stall_q} + {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rptr    <= '0;
         wptr    <= '0;
         count   <= '0;
         starve  <= '0;
         stall_q <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
         if (pop || empty) begin
            starve <= '0;
         end else if (starve_inc && (starve != SW'(STARVE_MAX))) begin
            starve <= starve + 1'b1;
         end
         stall_q <= stall_d;
      end
   end

   // Storage needs no reset: entries are only ever read after being pushed.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wptr] <= llu_rd_data_i;
         addr_mem[wptr] <= llu_rd_addr_i;
      end
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back stream (from mem_wb) and a long-latency unit (LLU: multi-cycle mul/div) that completes out of band.
- The pipeline has fixed priority. LLU results are queued in a small FIFO and drain on cycles when the pipeline does not write.
- A starvation counter forces a one-cycle pipeline stall so queued LLU results always retire.
- Sits between mem_wb and the regs file, in place of the plain write-back pass-through.

Parameters:
- XLEN, 32, register data width.
- FIFO_DEPTH, 2, LLU result queue entries (power of two, >=2).
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose arbitration before stall_o is raised (>=1).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- pipe_wen_i  in  1  pipeline write request.
- pipe_rd_addr_i  in  5  pipeline destination register.
- pipe_rd_data_i  in  XLEN  pipeline write data.
- pipe_instret_i  in  1  pipeline instruction retiring this cycle.
- llu_valid_i  in  1  LLU result valid.
- llu_ready_o  out  1  FIFO can accept a result.
- llu_rd_addr_i  in  5  LLU destination register.
- llu_rd_data_i  in  XLEN  LLU result.
- stall_o  out  1  registered; upstream must hold mem_wb and must not advance.
- regs_wen_o  out  1  register-file write enable.
- rd_addr_o  out  5  write address.
- rd_data_o  out  XLEN  write data.
- instret_cnt_o  out  2  instructions retired this cycle (0..2).
- fifo_cnt_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy (debug/scoreboard).

Behaviour:
- Reset (rstn=0 at posedge): FIFO empty, pointers 0, starve counter 0, stall_o=0.
- While rstn=0, all outputs are forced to 0, including llu_ready_o.
- Ready/accept: llu_ready_o = !full (not pop-aware). A push occurs on llu_valid_i && llu_ready_o. No bypass: a pushed result is written no earlier than the next cycle.
- Grant, combinational each cycle:
  - If stall_o=0 and pipe_wen_i=1: the pipeline wins. The regs_* outputs mirror the pipe_* inputs with zero latency.
  - Otherwise, if the FIFO is non-empty: the FIFO head wins and is popped at the clock edge.
  - Otherwise: regs_wen_o=0.
- x0 rule: a winning request with rd_addr=0 drives regs_wen_o=0. It still counts as granted, so a FIFO entry is still popped.
- While stall_o=1:
  - pipe_wen_i and pipe_instret_i are ignored; upstream re-presents the same instruction next cycle.
  - The FIFO head, if present, is granted.
- instret_cnt_o = (pipe_instret_i && !stall_o) + (FIFO pop this cycle). The value 2 is legal, e.g. a pipeline store retiring alongside an LLU drain.
- Starve counter:
  - Increments when the FIFO is non-empty and the pipeline won.
  - Clears on any FIFO pop or whenever the FIFO is empty.
  - Saturates; it never wraps.
- Stall generation:
  - When the counter increment reaches STARVE_MAX, stall_o=1 for exactly the next cycle.
  - The counter clears in that stall cycle because the FIFO pops.
  - stall_o never stays high for two consecutive cycles.
- Simultaneous push and pop:
  - When not full, occupancy is unchanged.
  - When full, no push is possible because ready is low. ready rises the cycle after the pop.
- Pointers wrap modulo FIFO_DEPTH. Occupancy never exceeds FIFO_DEPTH or goes below 0.
- Ordering:
  - FIFO entries drain in push order.
  - WAW/RAW ordering between the LLU and the pipeline is the issue scoreboard's responsibility. fifo_cnt_o is exported for it. This block never reorders within a source.
- Reset mid-operation: queued entries are discarded with no write. No partial writes are issued.

Test Plan:
1. Reset with llu_valid_i=1 and pipe_wen_i=1 -> all outputs 0, llu_ready_o=0. The cycle after release -> llu_ready_o=1, fifo_cnt_o=0.
2. Pipeline only: pipe_wen_i=1, rd=5, data=0xDEADBEEF, instret=1 -> same cycle regs_wen_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF, instret_cnt_o=1. With rd=0 -> regs_wen_o=0, instret_cnt_o=1.
3. LLU only: push rd=7, data=0x12 with the pipeline idle -> next cycle regs_wen_o=1, rd_addr_o=7, rd_data_o=0x12, instret_cnt_o=1. The cycle after that, fifo_cnt_o=0.
4. Starvation: push one LLU result while pipe_wen_i=1 continuously (STARVE_MAX=4) -> the pipeline writes for 4 cycles, stall_o=1 on the 5th cycle, the LLU entry is written that cycle, and stall_o=0 the cycle after.
5. Full FIFO: two pushes while the pipeline writes continuously -> fifo_cnt_o=2, llu_ready_o=0. A further llu_valid_i is not accepted. After one pop, ready=1 the next cycle. Entries drain in push order.
6. Dual retire: FIFO holds one entry; pipeline presents a store (wen=0, instret=1) -> the FIFO entry is written and instret_cnt_o=2.
